// File: rtl/ws_systolic_ctrl_pkg.sv
// Shared definitions for the weight-stationary systolic array sequencer.
package ws_systolic_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    COMPUTE,
    DRAIN,
    DONE
  } ws_state_e;

  // Cycles from an fmap vector entering the feed point to its result row
  // leaving the array, input/output skew included.
  function automatic int unsigned ws_lat(input int unsigned rows, input int unsigned cols);
    return rows + cols - 1;
  endfunction

endpackage

// File: rtl/ws_valid_pipe.sv
// Parameterised-depth 1-bit shift register with synchronous clear and an
// "any stage set" flag, used to track in-flight fmap vectors.
module ws_valid_pipe #(
  parameter int unsigned DEPTH = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic d_i,
  output logic q_o,
  output logic any_o
);

  logic [DEPTH-1:0] stages_q;

  // Shift one stage per cycle; reset and clear both empty the pipe.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      stages_q <= '0;
    end else begin
      stages_q[0] <= d_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stages_q[i] <= stages_q[i-1];
      end
    end
  end

  assign q_o   = stages_q[DEPTH-1];
  assign any_o = |stages_q;

endmodule

// File: rtl/ws_systolic_ctrl.sv
// Job sequencer for the weight-stationary systolic array: shifts the kernel
// vectors in, streams fmap vectors with back-pressure, then drains results.
module ws_systolic_ctrl
  import ws_systolic_ctrl_pkg::*;
#(
  parameter int unsigned row    = 3,
  parameter int unsigned column = 3,
  parameter int unsigned vec_w  = 16
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           start,
  input  logic [vec_w-1:0]                               num_vectors,
  input  logic                                           abort,
  input  logic                                           fmap_avail,
  output logic                                           op_sel,
  output logic                                           kernel_valid,
  output logic [((column > 1) ? $clog2(column) : 1)-1:0] kernel_idx,
  output logic                                           fmap_valid,
  output logic [vec_w-1:0]                               fmap_idx,
  output logic                                           result_valid,
  output logic [vec_w-1:0]                               result_idx,
  output logic                                           busy,
  output logic                                           done
);

  localparam int unsigned LAT = ws_lat(row, column);
  // The LAT-deep valid pipe is the sub-module (LAT-2 stages) followed by
  // tail_q and the result_valid register; needs row+column >= 4.
  localparam int unsigned PRE_DEPTH = LAT - 2;
  localparam int unsigned KW = (column > 1) ? $clog2(column) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(column - 1);

  ws_state_e        state_q;
  logic [KW-1:0]    kcnt_q;
  logic [vec_w-1:0] n_q;
  logic [vec_w-1:0] issue_q;
  logic             tail_q;
  logic             pipe_out;
  logic             pipe_any;
  logic             job_kill;

  assign job_kill = abort && (state_q != IDLE);

  ws_valid_pipe #(
    .DEPTH(PRE_DEPTH)
  ) u_valid_pipe (
    .clk  (clk),
    .rst  (rst),
    .clr_i(job_kill),
    .d_i  (fmap_valid),
    .q_o  (pipe_out),
    .any_o(pipe_any)
  );

  // Outputs are registered from the state held before each edge, so every
  // phase appears on the outputs one cycle after the state is entered. DRAIN
  // therefore exits once only the last two pipe stages can still be occupied,
  // which lands the done pulse one cycle after the final result_valid.
  always_ff @(posedge clk) begin
    if (rst || job_kill) begin
      state_q      <= IDLE;
      kcnt_q       <= '0;
      n_q          <= '0;
      issue_q      <= '0;
      tail_q       <= 1'b0;
      op_sel       <= 1'b0;
      kernel_valid <= 1'b0;
      kernel_idx   <= '0;
      fmap_valid   <= 1'b0;
      fmap_idx     <= '0;
      result_valid <= 1'b0;
      result_idx   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      op_sel       <= 1'b0;
      kernel_valid <= 1'b0;
      kernel_idx   <= '0;
      fmap_valid   <= 1'b0;
      done         <= 1'b0;
      busy         <= 1'b1;
      tail_q       <= pipe_out;
      result_valid <= tail_q;
      if (result_valid) begin
        result_idx <= result_idx + 1'b1;
      end
      case (state_q)
        IDLE: begin
          busy       <= 1'b0;
          fmap_idx   <= '0;
          issue_q    <= '0;
          result_idx <= '0;
          if (start) begin
            n_q     <= num_vectors;
            kcnt_q  <= K_LAST;
            state_q <= LOAD_W;
          end
        end
        LOAD_W: begin
          op_sel       <= 1'b1;
          kernel_valid <= 1'b1;
          kernel_idx   <= kcnt_q;
          if (kcnt_q == '0) begin
            state_q <= (n_q != '0) ? COMPUTE : DONE;
          end else begin
            kcnt_q <= kcnt_q - 1'b1;
          end
        end
        COMPUTE: begin
          fmap_valid <= fmap_avail;
          fmap_idx   <= issue_q;
          if (fmap_avail) begin
            issue_q <= issue_q + 1'b1;
            if (issue_q == n_q - 1'b1) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (!fmap_valid && !pipe_any) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          done       <= 1'b1;
          issue_q    <= '0;
          result_idx <= '0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ws_systolic_ctrl.sv
// Directed bench for ws_systolic_ctrl with row=column=3 (LAT=5).
module tb_ws_systolic_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] num_vectors;
  logic        abort;
  logic        fmap_avail;
  logic        op_sel;
  logic        kernel_valid;
  logic [1:0]  kernel_idx;
  logic        fmap_valid;
  logic [15:0] fmap_idx;
  logic        result_valid;
  logic [15:0] result_idx;
  logic        busy;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  ws_systolic_ctrl #(
    .row   (3),
    .column(3),
    .vec_w (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_vectors (num_vectors),
    .abort       (abort),
    .fmap_avail  (fmap_avail),
    .op_sel      (op_sel),
    .kernel_valid(kernel_valid),
    .kernel_idx  (kernel_idx),
    .fmap_valid  (fmap_valid),
    .fmap_idx    (fmap_idx),
    .result_valid(result_valid),
    .result_idx  (result_idx),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int c, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, c, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag, input int c);
    chk(tag, c, {24'd0, op_sel, kernel_valid, kernel_idx, fmap_valid, fmap_idx,
                 result_valid, result_idx, busy, done}, 64'd0);
  endtask

  // One job: start sampled at relative cycle 0; expectations given as
  // per-cycle masks / windows worked out by hand from the timing rules.
  task automatic run_job(input logic [15:0] n, input logic [31:0] avail,
                         input int start2_c, input int abort_c,
                         input logic [31:0] fv_m, input logic [31:0] rv_m,
                         input int busy_end, input int done_c, input int ncyc);
    int  fcnt;
    int  rcnt;
    bit  load;
    fcnt = 0;
    rcnt = 0;
    num_vectors = n;
    for (int c = 0; c <= ncyc; c++) begin
      start      = (c == 0) || (c == start2_c);
      abort      = (c == abort_c);
      fmap_avail = avail[c];
      tick();
      start = 1'b0;
      abort = 1'b0;
      load  = (c >= 1) && (c <= 3) && (c <= busy_end);
      chk("op_sel", c, 64'(op_sel), 64'(load));
      chk("kernel_valid", c, 64'(kernel_valid), 64'(load));
      chk("kernel_idx", c, 64'(kernel_idx), load ? 64'(3 - c) : 64'd0);
      chk("busy", c, 64'(busy), 64'((c >= 1) && (c <= busy_end)));
      chk("done", c, 64'(done), 64'(c == done_c));
      chk("fmap_valid", c, 64'(fmap_valid), 64'(fv_m[c]));
      if (fv_m[c]) begin
        chk("fmap_idx", c, 64'(fmap_idx), 64'(fcnt));
        fcnt++;
      end
      chk("result_valid", c, 64'(result_valid), 64'(rv_m[c]));
      if (rv_m[c]) begin
        chk("result_idx", c, 64'(result_idx), 64'(rcnt));
        rcnt++;
      end
    end
    fmap_avail = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    abort       = 1'b0;
    fmap_avail  = 1'b0;
    num_vectors = '0;
    tick();
    tick();
    chk_idle("reset_state", 0);
    rst = 1'b0;
    tick();
    chk_idle("idle_after_reset", 0);

    // 1: four vectors, source always ready
    run_job(16'd4, 32'hFFFF_FFFF, -1, -1, 32'h0000_00F0, 32'h0000_1E00, 13, 13, 15);
    // 2: bubble in cycle 5
    run_job(16'd3, ~32'h0000_0020, -1, -1, 32'h0000_00D0, 32'h0000_1A00, 13, 13, 15);
    // 3: preload-only job
    run_job(16'd0, 32'hFFFF_FFFF, -1, -1, 32'h0, 32'h0, 4, 4, 8);
    // 4: abort in cycle 6 of an 8-vector job, then a clean 2-vector job
    run_job(16'd8, 32'hFFFF_FFFF, -1, 6, 32'h0000_0030, 32'h0, 5, -1, 7);
    run_job(16'd2, 32'hFFFF_FFFF, -1, -1, 32'h0000_0030, 32'h0000_0600, 11, 11, 13);
    // 5: second start pulse mid-job is ignored
    run_job(16'd4, 32'hFFFF_FFFF, 5, -1, 32'h0000_00F0, 32'h0000_1E00, 13, 13, 15);
    // start and abort together in IDLE: job still starts
    run_job(16'd1, 32'hFFFF_FFFF, -1, 0, 32'h0000_0010, 32'h0000_0200, 10, 10, 12);

    // 6: synchronous reset during COMPUTE
    num_vectors = 16'd4;
    fmap_avail  = 1'b1;
    start       = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 4; c++) tick();
    chk("busy_before_rst", 4, 64'(busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle("rst_midjob", 5);
    for (int c = 6; c <= 15; c++) begin
      tick();
      chk_idle("after_rst", c);
    end
    fmap_avail = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ws_systolic_ctrl.md
Name: ws_systolic_ctrl

Overview:
Sequencer for the weight-stationary systolic array. It runs one job per start pulse. First it shifts COLUMN kernel vectors into the array with op_sel=1. It then streams num_vectors fmap vectors with op_sel=0, stalling whenever the source is not ready. Finally it drains the array and flags each valid result row. It sits between the job/buffer layer (kernel and fmap SRAM readers, result writer) and the array's Op_sel / feed-valid controls.

Parameters:
row, 3, PE rows per column (array height)
column, 3, PE columns (number of kernel vectors to shift in)
vec_w, 16, width of the vector-count fields
LAT, row+column-1, derived localparam: cycles from fmap_valid at the feed point to the matching result at Result_out (skew included)

Ports:
clk  input  1  clock, all logic rising-edge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle job request; sampled only in IDLE
num_vectors  input  vec_w  fmap vectors in the job; latched on accepted start
abort  input  1  synchronous job cancel
fmap_avail  input  1  fmap source has a vector ready this cycle
op_sel  output  1  array Op_sel: 1 = shift/load kernel, 0 = compute
kernel_valid  output  1  kernel reader must present kernel_idx this cycle
kernel_idx  output  $clog2(column)  kernel vector index being shifted in
fmap_valid  output  1  fmap vector consumed this cycle
fmap_idx  output  vec_w  index of consumed fmap vector
result_valid  output  1  Result_out holds a valid result row
result_idx  output  vec_w  index of the current result row
busy  output  1  job in progress (any state except IDLE)
done  output  1  one-cycle pulse at job completion

Behaviour:
- States: IDLE, LOAD_W, COMPUTE, DRAIN, DONE. All outputs are registered.
- Reset: state=IDLE; all counters and the valid pipe cleared; every output 0, including op_sel=0 and all indices 0.
- IDLE: on start=1, latch num_vectors and go to LOAD_W. start while not IDLE is ignored.
- LOAD_W: lasts exactly column cycles. op_sel=1, kernel_valid=1, kernel_idx counts down column-1 .. 0, so column j ends up holding kernel j.
  - Exit to COMPUTE if the latched count is greater than 0, otherwise to DONE (preload-only job).
- COMPUTE: op_sel=0.
  - Each cycle with fmap_avail=1: fmap_valid=1, fmap_idx = issue counter, counter increments.
  - fmap_avail=0: fmap_valid=0 (bubble) and the counter holds. The array keeps shifting.
  - The cycle that issues index num_vectors-1 is followed by DRAIN.
- Valid pipe: a LAT-deep shift register fed by fmap_valid, advancing every cycle in every state.
  - result_valid = its output, so it occurs exactly LAT cycles after the matching fmap_valid, with bubbles preserved.
  - result_idx increments after each result_valid cycle.
- DRAIN: op_sel=0, fmap_valid=0. Move to DONE in the cycle after the pipe becomes empty, i.e. one cycle after the last result_valid.
- DONE: done=1 for one cycle, busy=1, then IDLE. Job counters are cleared on entering IDLE.
- busy=1 in LOAD_W, COMPUTE, DRAIN and DONE.
- abort (any non-IDLE state): IDLE on the next edge. Pipe and counters are cleared, op_sel=0, no done pulse. abort in IDLE has no effect. abort takes priority over all other transitions.
- start and abort asserted together in IDLE: the job starts.
- Width rules: counters are vec_w bits. The maximum job is 2^vec_w-1 vectors, so no wrap-around is possible.

Decomposition:
- Shared package: state enum (IDLE, LOAD_W, COMPUTE, DRAIN, DONE) and the LAT formula function. The array wrapper reuses the formula.
- One sub-module is natural: ws_valid_pipe, a parameterised-depth 1-bit shift register with a synchronous clear and an "any bit set" output.

Test Plan (row=column=3, LAT=5, start sampled at cycle 0):
1. start, num_vectors=4, fmap_avail=1 -> op_sel=1 and kernel_idx 2,1,0 in cycles 1-3; fmap_valid cycles 4-7 (idx 0-3); result_valid cycles 9-12 (idx 0-3); done cycle 13; busy cycles 1-13.
2. num_vectors=3, fmap_avail low in cycle 5 only -> fmap_valid cycles 4, 6, 7; result_valid cycles 9, 11, 12; done cycle 13.
3. num_vectors=0 -> LOAD_W cycles 1-3, done cycle 4, no fmap_valid or result_valid at any time.
4. abort in cycle 6 of a num_vectors=8 job -> IDLE at cycle 7; all outputs 0; no done, no further result_valid. A new start at cycle 8 runs a clean job.
5. start pulsed again at cycle 5 of the job in scenario 1 -> ignored; timing identical to scenario 1.
6. rst asserted for one cycle during COMPUTE -> next cycle every output 0, state IDLE; valid pipe empty, so no stale result_valid appears.
